// File: rtl/vga_pkg.sv
// Shared VGA definitions: frame geometry, pixel format, colours and the
// frame-buffer clear-engine state type.
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int PIX_COUNT = H_ACTIVE * V_ACTIVE;

    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 3;

    localparam logic [COLOR_W-1:0] BLACK = 3'd0;
    localparam logic [COLOR_W-1:0] GREEN = 3'd2;
    localparam logic [COLOR_W-1:0] WHITE = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } vram_state;

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port frame RAM shaped for block-RAM inference: one write
// port, one registered read port, read-first on address collision.
// Out-of-range read addresses return zero; the array itself is never reset.
module vram_dp #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 3,
    parameter int DEPTH   = 307200
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [COLOR_W-1:0] rdata
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [COLOR_W-1:0] mem [DEPTH];

    // Write port; callers guarantee waddr is in range when we is high.
    always_ff @(posedge Clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; the non-blocking array update makes it read-first.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)              rdata <= '0;
        else if (raddr <= LAST) rdata <= mem[raddr];
        else                    rdata <= '0;
    end

endmodule

// File: rtl/vram_ctrl.sv
// Frame buffer in front of the VGA timing block: never-stalling pixel read
// port, valid/ready draw port, and a whole-frame clear engine.
// Optional macro VRAM_AUTO_CLEAR_EN: start a clear automatically on the
// first cycle after reset is released.
module vram_ctrl
    import vga_pkg::*;
#(
    parameter int                 DEPTH       = PIX_COUNT,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = BLACK
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  iReadAddress,
    output logic [COLOR_W-1:0] oReadColor,
    input  logic               iWriteValid,
    input  logic [ADDR_W-1:0]  iWriteAddress,
    input  logic [COLOR_W-1:0] iWriteColor,
    output logic               oWriteReady,
    input  logic               iClearReq,
    output logic               oClearBusy,
    output logic               oClearDone
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    vram_state          state, state_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               clear_go;
    logic               user_we;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [COLOR_W-1:0] ram_wdata;

`ifdef VRAM_AUTO_CLEAR_EN
    logic auto_pend;

    // High for exactly the first cycle after reset release to kick a clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) auto_pend <= 1'b1;
        else       auto_pend <= 1'b0;
    end

    assign clear_go = iClearReq | auto_pend;
`else
    assign clear_go = iClearReq;
`endif

    // State register; reset aborts any clear in flight without a done pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Clear address: zeroed while idle, walks 0..DEPTH-1 and holds at the end.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                                 clr_cnt <= '0;
        else if (state == IDLE)                    clr_cnt <= '0;
        else if (state == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
    end

    // Next-state and status outputs; a clear request beats a user write.
    always_comb begin
        state_nxt   = state;
        oWriteReady = 1'b0;
        oClearBusy  = 1'b0;
        oClearDone  = 1'b0;
        case (state)
            IDLE: begin
                oWriteReady = !clear_go;
                if (clear_go) state_nxt = CLEAR;
            end
            CLEAR: begin
                oClearBusy = 1'b1;
                if (clr_cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                oClearDone = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range user writes are dropped here so the RAM never sees them.
    assign user_we   = iWriteValid && oWriteReady && (iWriteAddress <= LAST);
    assign ram_we    = oClearBusy || user_we;
    assign ram_waddr = oClearBusy ? clr_cnt     : iWriteAddress;
    assign ram_wdata = oClearBusy ? CLEAR_COLOR : iWriteColor;

    vram_dp #(
        .ADDR_W  (ADDR_W),
        .COLOR_W (COLOR_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .Clock (Clock),
        .Reset (Reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (iReadAddress),
        .rdata (oReadColor)
    );

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl on a reduced frame (DEPTH=2048) so that
// full clears stay short. A plain array models the frame contents.
module tb_vram_ctrl;
    import vga_pkg::*;

    localparam int DEPTH = 2048;

    logic               Clock = 1'b0;
    logic               Reset;
    logic [ADDR_W-1:0]  iReadAddress;
    logic [COLOR_W-1:0] oReadColor;
    logic               iWriteValid;
    logic [ADDR_W-1:0]  iWriteAddress;
    logic [COLOR_W-1:0] iWriteColor;
    logic               oWriteReady;
    logic               iClearReq;
    logic               oClearBusy;
    logic               oClearDone;

    always #5 Clock = ~Clock;

    vram_ctrl #(.DEPTH(DEPTH), .CLEAR_COLOR(BLACK)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iReadAddress  (iReadAddress),
        .oReadColor    (oReadColor),
        .iWriteValid   (iWriteValid),
        .iWriteAddress (iWriteAddress),
        .iWriteColor   (iWriteColor),
        .oWriteReady   (oWriteReady),
        .iClearReq     (iClearReq),
        .oClearBusy    (oClearBusy),
        .oClearDone    (oClearDone)
    );

    logic [COLOR_W-1:0] model [DEPTH];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [COLOR_W-1:0] model_read(input int a);
        if (a < DEPTH) return model[a];
        return '0;
    endfunction

    // One idle-state cycle: present inputs, check ready, then check the read
    // data one edge later against the model (read-first).
    task automatic cycle(input int rd, input logic wv, input int wa,
                         input logic [COLOR_W-1:0] wc, input logic clr, input string tag);
        logic [COLOR_W-1:0] exp_rd;
        logic               exp_rdy;
        iReadAddress  = rd[ADDR_W-1:0];
        iWriteValid   = wv;
        iWriteAddress = wa[ADDR_W-1:0];
        iWriteColor   = wc;
        iClearReq     = clr;
        #1;
        exp_rdy = !clr;
        check({tag, ".rdy"}, 32'(oWriteReady), 32'(exp_rdy));
        exp_rd = model_read(rd);
        if (wv && exp_rdy && wa < DEPTH) model[wa] = wc;
        @(posedge Clock); #1;
        check({tag, ".rd"}, 32'(oReadColor), 32'(exp_rd));
        iWriteValid = 1'b0;
        iClearReq   = 1'b0;
    endtask

    // Called just after the edge that entered CLEAR; follows it to IDLE.
    task automatic wait_clear(input string tag);
        int busy_n = 0;
        int rdy_bad = 0;
        int done_n = 0;
        while (oClearBusy === 1'b1 && busy_n < DEPTH + 10) begin
            busy_n++;
            if (oWriteReady !== 1'b0) rdy_bad++;
            if (oClearDone !== 1'b0) done_n++;
            iClearReq = (busy_n == 10);   // must be ignored mid-clear
            @(posedge Clock); #1;
        end
        iClearReq = 1'b0;
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'(DEPTH));
        check({tag, ".rdy_in_clear"}, 32'(rdy_bad), 32'd0);
        check({tag, ".done_in_clear"}, 32'(done_n), 32'd0);
        check({tag, ".done_pulse"}, 32'(oClearDone), 32'd1);
        check({tag, ".rdy_done"}, 32'(oWriteReady), 32'd0);
        @(posedge Clock); #1;
        check({tag, ".done_end"}, 32'(oClearDone), 32'd0);
        check({tag, ".no_requeue"}, 32'(oClearBusy), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = BLACK;
    endtask

    initial begin
        int n;
        logic [COLOR_W-1:0] exp_last;

        Reset = 1'b1;
        iReadAddress = '0; iWriteValid = 1'b0; iWriteAddress = '0;
        iWriteColor = '0; iClearReq = 1'b0;
        #12;
        check("reset.color", 32'(oReadColor), 32'd0);
        check("reset.busy", 32'(oClearBusy), 32'd0);
        check("reset.done", 32'(oClearDone), 32'd0);
`ifndef VRAM_AUTO_CLEAR_EN
        check("reset.rdy", 32'(oWriteReady), 32'd1);
`endif
        @(negedge Clock); Reset = 1'b0;
        @(posedge Clock); #1;
`ifdef VRAM_AUTO_CLEAR_EN
        check("auto.busy", 32'(oClearBusy), 32'd1);
        wait_clear("auto");
`endif

        // Dirty the spot-check locations, then clear the whole frame.
        cycle(DEPTH, 1'b1, 0, WHITE, 1'b0, "pre0");
        cycle(DEPTH, 1'b1, DEPTH/2, WHITE, 1'b0, "premid");
        cycle(DEPTH, 1'b1, DEPTH-1, WHITE, 1'b0, "prelast");
        cycle(DEPTH, 1'b0, 0, '0, 1'b1, "clr1_start");
        wait_clear("clr1");
        cycle(0, 1'b0, 0, '0, 1'b0, "clr1_a0");
        cycle(DEPTH/2, 1'b0, 0, '0, 1'b0, "clr1_amid");
        cycle(DEPTH-1, 1'b0, 0, '0, 1'b0, "clr1_alast");

        // Basic write then read, 1-cycle latency.
        cycle(DEPTH, 1'b1, 1000, 3'd5, 1'b0, "w1000");
        cycle(1000, 1'b0, 0, '0, 1'b0, "r1000");

        // Same-cycle read/write collision is read-first.
        cycle(DEPTH, 1'b1, 42, 3'd1, 1'b0, "w42");
        cycle(42, 1'b1, 42, 3'd7, 1'b0, "rw42");
        cycle(42, 1'b0, 0, '0, 1'b0, "r42");

        // Random traffic including out-of-range addresses.
        repeat (300) begin
            cycle(int'($urandom_range(0, DEPTH + 15)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, DEPTH + 15)), 3'($urandom_range(0, 7)),
                  1'b0, "rand");
        end

        // Out-of-range reads return zero, out-of-range writes change nothing.
        cycle(DEPTH, 1'b1, 400000, 3'd4, 1'b0, "oor_w");
        cycle(DEPTH, 1'b1, DEPTH, 3'd3, 1'b0, "oor_edge");
        cycle(0, 1'b0, 0, '0, 1'b0, "oor_spot0");
        cycle(DEPTH-1, 1'b0, 0, '0, 1'b0, "oor_spotlast");

        // Clear request and write in the same cycle: clear wins.
        cycle(DEPTH, 1'b1, 5, 3'd2, 1'b0, "w5");
        cycle(5, 1'b1, 5, 3'd6, 1'b1, "clr_wr");
        wait_clear("clr2");
        cycle(5, 1'b0, 0, '0, 1'b0, "clr2_a5");

        // Reset in the middle of a clear.
        cycle(DEPTH, 1'b1, 0, 3'd6, 1'b0, "w0");
        cycle(DEPTH, 1'b1, DEPTH-1, 3'd3, 1'b0, "wlast");
        cycle(DEPTH, 1'b0, 0, '0, 1'b1, "clr3_start");
        repeat (100) @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("mid.busy", 32'(oClearBusy), 32'd0);
        check("mid.done", 32'(oClearDone), 32'd0);
        check("mid.color", 32'(oReadColor), 32'd0);
        @(negedge Clock); Reset = 1'b0;
        n = 0;
        while (oClearDone !== 1'b1 && n < DEPTH + 20) begin
            @(posedge Clock); #1;
            n++;
        end
`ifdef VRAM_AUTO_CLEAR_EN
        check("mid.auto_done_at", 32'(n), 32'(DEPTH + 1));
        @(posedge Clock); #1;
        for (int i = 0; i < DEPTH; i++) model[i] = BLACK;
        exp_last = BLACK;
`else
        check("mid.no_done", 32'(n), 32'(DEPTH + 20));
        model[0] = BLACK;
        exp_last = 3'd3;
`endif
        check("mid.model_last", 32'(model[DEPTH-1]), 32'(exp_last));
        cycle(0, 1'b0, 0, '0, 1'b0, "mid_a0");
        cycle(DEPTH-1, 1'b0, 0, '0, 1'b0, "mid_alast");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_ctrl.md
Name: vram_ctrl

Overview:
Frame-buffer stage directly upstream of the VGA timing block. It holds one 640x480 frame of 3-bit pixels.
- Read port: serves the VGA block's pixel address (oColorAddress) and returns the colour it displays.
- Write port: a valid/ready port for drawing logic.
- Clear engine: an FSM-driven whole-screen clear that fills the frame with a fixed colour.

Parameters:
ADDR_W, 19, pixel address width
COLOR_W, 3, bits per pixel (RGB 1-1-1)
DEPTH, 307200, number of pixels (640*480)
CLEAR_COLOR, 3'd0, value written by the clear engine

Ports:
Clock  in  1  system clock (same domain as the VGA pixel-rate logic)
Reset  in  1  asynchronous, active-high reset
iReadAddress  in  ADDR_W  pixel address from the VGA block
oReadColor  out  COLOR_W  pixel colour, registered, 1-cycle latency
iWriteValid  in  1  write request
iWriteAddress  in  ADDR_W  write pixel address
iWriteColor  in  COLOR_W  write pixel colour
oWriteReady  out  1  write port can accept
iClearReq  in  1  start a full-frame clear (level or pulse; sampled in IDLE)
oClearBusy  out  1  clear in progress
oClearDone  out  1  one-cycle pulse when the clear finishes

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - oReadColor=0, oClearBusy=0, oClearDone=0.
  - FSM=IDLE, clear counter=0.
  - RAM contents are not reset.
- Read path:
  - oReadColor <= RAM[iReadAddress] every cycle, so latency is exactly 1 cycle.
  - If iReadAddress >= DEPTH, oReadColor <= 0 on the next cycle.
  - Reads never stall, including during a clear.
- Write path:
  - oWriteReady = (state==IDLE) && !iClearReq (combinational).
  - A write is accepted when iWriteValid && oWriteReady. RAM[iWriteAddress] updates on that edge.
  - An accepted write with iWriteAddress >= DEPTH is silently dropped.
  - Read and write to the same address in the same cycle: read-first, i.e. oReadColor shows the old value. The new value is visible on a read one cycle later.
- FSM:
  - IDLE: iClearReq=1 -> CLEAR, with counter <= 0. Otherwise stay.
  - CLEAR:
    - Each cycle writes CLEAR_COLOR to RAM[counter], then counter++.
    - oClearBusy=1 and oWriteReady=0; user writes are held off, never lost or merged.
    - When counter==DEPTH-1 that write is the last one -> DONE.
  - DONE: oClearDone=1 for exactly one cycle, oClearBusy=0 -> IDLE.
- Clear duration: DEPTH cycles in CLEAR plus 1 cycle in DONE.
- Simultaneous events:
  - iClearReq and iWriteValid asserted together in IDLE: the clear wins and the write is not accepted (ready=0).
  - iClearReq asserted during CLEAR or DONE is ignored; it is not queued.
  - iClearReq still high on return to IDLE starts a new clear.
- Reset mid-clear: the clear aborts immediately, the FSM goes to IDLE, no done pulse is issued, and the RAM is left partially cleared.
- Counter wrap: the counter never exceeds DEPTH-1. Width is ADDR_W, and the compare is exact.

Optional Feature:
VRAM_AUTO_CLEAR_EN
- Defined: the first cycle after Reset deasserts, the FSM enters CLEAR as if iClearReq were asserted. The frame is therefore known-clean before the VGA block shows it, and oClearDone pulses at the end as usual.
- Undefined: after reset the FSM stays in IDLE until iClearReq, and RAM power-up contents are displayed as-is.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE=640, V_ACTIVE=480, PIX_COUNT=H_ACTIVE*V_ACTIVE.
  - ADDR_W=19, COLOR_W=3.
  - Colour constants (BLACK=3'd0, GREEN=3'd2, WHITE=3'd7).
  - The vram_state enum {IDLE, CLEAR, DONE}.
- Sub-module vram_dp: a simple dual-port RAM written for block-RAM inference.
  - One write port and one registered read port, with read-first semantics.
  - No reset on the array.
  - vram_ctrl instantiates it and muxes the write port between the user and the clear engine.

Test Plan:
- Write 3'd5 to addr 1000 (valid=1, ready=1) then read 1000 -> oReadColor=3'd5 exactly 1 cycle after the address is presented.
- Same-cycle write 3'd7 and read at addr 42, where the old value is 3'd1 -> oReadColor=3'd1 next cycle, then 3'd7 on a read one cycle later.
- Pulse iClearReq -> oClearBusy high for 307200 cycles and oWriteReady=0 throughout; oClearDone pulses once; reads of addr 0, 153600 and 307199 then return 3'd0.
- iClearReq and iWriteValid (addr 5, 3'd6) in the same cycle -> write not accepted, clear starts; after done, addr 5 reads 3'd0.
- Read addr 307200 and write 3'd4 to addr 400000 -> oReadColor=0, and no RAM location changes (spot-check addr 0 and 307199).
- Assert Reset at clear cycle 100 -> outputs return to reset values asynchronously and no done pulse occurs. With VRAM_AUTO_CLEAR_EN defined, a clear restarts after deassert and oClearDone pulses 307201 cycles later.
